rst_seq_artys7: RTL and testbench



---
 rtl/rst_seq_artys7.sv | 133 +++++++++++++
 tb/tb_rst_seq_artys7.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_artys7.sv
// Reset sequencer: synchronises and debounces MMCM lock, then releases the
// system reset and, after a delay, the core reset; handles lock loss and soft reset.
module rst_seq_artys7 #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CORE_DELAY_CYCLES  = 16,
  parameter int CNT_W              = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             locked_i,
  input  logic             soft_rst_req_i,
  output logic             rst_sys_no,
  output logic             rst_core_no,
  output logic             seq_busy_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ?
                           LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]    LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    CORE_LAST = CW'(CORE_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_MAX  = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SYS_UP,
    RUN,
    SOFT_RST
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   rst_sys_q, rst_core_q, busy_q;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
    end
  end

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_cnt_d = loss_cnt_q;

    case (state_q)
      WAIT_LOCK: begin
        if (!locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = SYS_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SYS_UP: begin
        if (cnt_q == CORE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (soft_rst_req_i) begin
          state_d = SOFT_RST;
          cnt_d   = '0;
        end
      end
      SOFT_RST: begin
        // A repeated request restarts the hold, even on its final cycle.
        if (soft_rst_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == CORE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Lock loss after system release overrides everything, including soft requests.
    if (state_q != WAIT_LOCK && !locked_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      if (loss_cnt_q != LOSS_MAX) begin
        loss_cnt_d = loss_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      loss_cnt_q <= '0;
      rst_sys_q  <= 1'b0;
      rst_core_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_cnt_q <= loss_cnt_d;
      rst_sys_q  <= (state_d != WAIT_LOCK);
      rst_core_q <= (state_d == RUN);
      busy_q     <= (state_d != RUN);
    end
  end

  assign rst_sys_no      = rst_sys_q;
  assign rst_core_no     = rst_core_q;
  assign seq_busy_o      = busy_q;
  assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_rst_seq_artys7.sv
// Self-checking bench for rst_seq_artys7: directed power-up table, multi-cycle
// corner sequences, then randomized lock/soft-reset traffic against a timestamp model.
module tb_rst_seq_artys7;

  localparam int SYNC     = 2;
  localparam int LSC      = 16;
  localparam int CDC      = 4;
  localparam int CW       = 2;
  localparam int LOSS_MAX = (1 << CW) - 1;
  localparam int BIG      = 1000;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          locked_i;
  logic          soft_rst_req_i;
  logic          rst_sys_no;
  logic          rst_core_no;
  logic          seq_busy_o;
  logic [CW-1:0] lock_loss_cnt_o;

  always #10 clk = ~clk;

  rst_seq_artys7 #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .CORE_DELAY_CYCLES (CDC),
    .CNT_W             (CW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .locked_i       (locked_i),
    .soft_rst_req_i (soft_rst_req_i),
    .rst_sys_no     (rst_sys_no),
    .rst_core_no    (rst_core_no),
    .seq_busy_o     (seq_busy_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: lock seen through a delay line; sys is up after LSC consecutive
  // synchronised-high cycles; core is up once both the time since system
  // release and the time since the last accepted soft request reach CDC.
  bit mq[$];
  int m_run;
  bit m_up;
  int m_since_rel;
  int m_since_soft;
  int m_loss;

  function automatic bit m_core();
    return m_up && (m_since_rel >= CDC) && (m_since_soft >= CDC);
  endfunction

  task automatic model_reset();
    mq.delete();
    repeat (SYNC) mq.push_back(1'b0);
    m_run        = 0;
    m_up         = 0;
    m_since_rel  = 0;
    m_since_soft = BIG;
    m_loss       = 0;
  endtask

  task automatic model_edge(input bit lk, input bit sr);
    bit ls;
    bit core_phase;
    ls = mq.pop_front();
    mq.push_back(lk);
    core_phase = m_up && (m_since_rel >= CDC);
    if (!ls) begin
      if (m_up && m_loss < LOSS_MAX) m_loss++;
      m_up  = 0;
      m_run = 0;
    end else if (!m_up) begin
      m_run++;
      if (m_run == LSC) begin
        m_up         = 1;
        m_since_rel  = 0;
        m_since_soft = BIG;
      end
    end else begin
      if (m_since_rel < BIG) m_since_rel++;
      if (m_since_soft < BIG) m_since_soft++;
      if (sr && core_phase) m_since_soft = 0;
    end
  endtask

  task automatic cycle(input bit lk, input bit sr);
    @(negedge clk);
    locked_i       = lk;
    soft_rst_req_i = sr;
    @(posedge clk);
    model_edge(lk, sr);
    #1;
    check("model_sys", rst_sys_no, m_up);
    check("model_core", rst_core_no, m_core());
    check("model_busy", seq_busy_o, !m_core());
    check("model_cnt", lock_loss_cnt_o, m_loss);
  endtask

  task automatic wait_core(output int n);
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      cycle(1'b1, 1'b0);
      if (rst_core_no === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit lk;
    bit sr;
    bit e_sys;
    bit e_core;
    bit e_busy;
    int e_cnt;
  } vec_t;

  vec_t pwr[24];

  initial begin
    int n, fall_at, sys_at, core_at, len, low_left;
    bit any_sys, sys_held;
    bit lk, sr;

    // Power-up table: edge e (1-based) after reset release, lock high throughout.
    for (int e = 1; e <= 24; e++) begin
      pwr[e-1] = '{lk: 1'b1, sr: 1'b0, e_sys: (e >= 18), e_core: (e >= 22),
                   e_busy: (e < 22), e_cnt: 0};
    end
    pwr[4].sr  = 1'b1;  // soft request in WAIT_LOCK: ignored
    pwr[18].sr = 1'b1;  // soft request in SYS_UP: ignored

    rst_i          = 1'b1;
    locked_i       = 1'b0;
    soft_rst_req_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sys", rst_sys_no, 0);
    check("rst_core", rst_core_no, 0);
    check("rst_busy", seq_busy_o, 1);
    check("rst_cnt", lock_loss_cnt_o, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 24; i++) begin
      cycle(pwr[i].lk, pwr[i].sr);
      check($sformatf("pwr_sys_e%0d", i + 1), rst_sys_no, pwr[i].e_sys);
      check($sformatf("pwr_core_e%0d", i + 1), rst_core_no, pwr[i].e_core);
      check($sformatf("pwr_busy_e%0d", i + 1), seq_busy_o, pwr[i].e_busy);
      check($sformatf("pwr_cnt_e%0d", i + 1), lock_loss_cnt_o, pwr[i].e_cnt);
    end

    // Lock loss in RUN: one-cycle drop (edge 1), lock back before edge 2.
    fall_at = -1; sys_at = -1; core_at = -1;
    cycle(1'b0, 1'b0);
    for (int k = 2; k <= 60; k++) begin
      cycle(1'b1, 1'b0);
      if (fall_at < 0 && rst_sys_no === 1'b0) begin
        fall_at = k;
        check("loss_core_low", rst_core_no, 0);
        check("loss_cnt", lock_loss_cnt_o, 1);
      end else if (fall_at > 0 && sys_at < 0 && rst_sys_no === 1'b1) begin
        sys_at = k;
      end
      if (sys_at > 0 && rst_core_no === 1'b1) begin
        core_at = k;
        break;
      end
    end
    check("loss_fall_edge", fall_at, 3);
    check("loss_resys_edge", sys_at, 19);
    check("loss_recore_edge", core_at, 23);

    // Debounce: lose lock, then a 10-high / 3-low glitch, then steady lock.
    repeat (5) cycle(1'b0, 1'b0);
    check("deb_lost_sys", rst_sys_no, 0);
    any_sys = 1'b0;
    repeat (10) begin cycle(1'b1, 1'b0); any_sys |= rst_sys_no; end
    repeat (3) begin cycle(1'b0, 1'b0); any_sys |= rst_sys_no; end
    check("deb_glitch_hold", any_sys, 0);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b1, 1'b0);
      if (rst_sys_no === 1'b1) begin n = k; break; end
    end
    check("deb_release_edge", n, 18);
    wait_core(n);
    check("deb_core_up", rst_core_no, 1);

    // Soft reset, single pulse: core low for 4 cycles, sys held, count unchanged.
    sys_held = 1'b1;
    cycle(1'b1, 1'b1);
    len = (rst_core_no === 1'b0) ? 1 : 0;
    for (int k = 0; k < 20 && rst_core_no !== 1'b1; k++) begin
      cycle(1'b1, 1'b0);
      sys_held &= rst_sys_no;
      if (rst_core_no === 1'b0) len++;
    end
    check("soft_len", len, 4);
    check("soft_sys_held", sys_held, 1);
    check("soft_cnt", lock_loss_cnt_o, 2);

    // Soft reset, second pulse two cycles into the hold: 6 cycles total.
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    len = 3;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0);
      sys_held &= rst_sys_no;
      if (rst_core_no === 1'b1) break;
      len++;
    end
    check("soft2_len", len, 6);
    check("soft2_sys_held", sys_held, 1);

    // Saturation: five more lock losses, counter sticks at 3.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      wait_core(n);
      check($sformatf("sat_reseq_%0d", i), rst_core_no, 1);
    end
    check("sat_cnt", lock_loss_cnt_o, LOSS_MAX);

    // Priority: soft request on the same edge the FSM sees lock loss.
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check("prio_sys", rst_sys_no, 0);
    check("prio_core", rst_core_no, 0);
    check("prio_busy", seq_busy_o, 1);
    check("prio_cnt", lock_loss_cnt_o, LOSS_MAX);

    // Async reset mid-SYS_UP, between clock edges.
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b1, 1'b0);
      if (rst_sys_no === 1'b1) begin n = k; break; end
    end
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("async_pre_sys", rst_sys_no, 1);
    check("async_pre_core", rst_core_no, 0);
    @(negedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    check("async_sys", rst_sys_no, 0);
    check("async_core", rst_core_no, 0);
    check("async_busy", seq_busy_o, 1);
    check("async_cnt", lock_loss_cnt_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("async_hold_sys", rst_sys_no, 0);
    rst_i = 1'b0;
    model_reset();
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b1, 1'b0);
      if (rst_sys_no === 1'b1) begin n = k; break; end
    end
    check("async_resys_edge", n, 18);

    // Randomized lock drops and soft requests against the model.
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left > 0) begin
        lk = 1'b0;
        low_left--;
      end else if ($urandom_range(0, 99) == 0) begin
        lk = 1'b0;
        low_left = $urandom_range(0, 5);
      end else begin
        lk = 1'b1;
      end
      sr = ($urandom_range(0, 19) == 0);
      cycle(lk, sr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
